// File: rtl/fifo_drain_stage.sv
// Drains a pop/empty FIFO into a registered valid/ready stream through a 2-entry skid buffer.
// fifo_pop never depends on out_ready, so downstream backpressure has no combinational path upstream.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | nothing buffered, out_valid_r low
// S_ONE   | head word on out_data_r, skid register free
// S_TWO   | head word on out_data_r plus one word in skid
module fifo_drain_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_empty_r,
    output logic         fifo_pop,
    input  logic [W-1:0] fifo_pop_data,
    input  logic         flush,
    output logic         out_valid_r,
    output logic [W-1:0] out_data_r,
    input  logic         out_ready,
    output logic [1:0]   count_r
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   head_d;
    logic [W-1:0]   skid_q;
    logic [W-1:0]   skid_d;
    logic [1:0]     count_d;
    logic           deq;

    // Popping is refused only when both slots are full, which is what keeps the pop path free of out_ready.
    assign fifo_pop = ~rst & ~flush & ~fifo_empty_r & (state_q != S_TWO);
    assign deq      = out_valid_r & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = out_data_r;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (fifo_pop) begin
                    state_d = S_ONE;
                    head_d  = fifo_pop_data;
                end
            end
            S_ONE: begin
                if (fifo_pop && deq) begin
                    head_d = fifo_pop_data;
                end else if (fifo_pop) begin
                    state_d = S_TWO;
                    skid_d  = fifo_pop_data;
                end else if (deq) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (deq) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush discards buffered words; a deq in the same cycle still counts as delivered downstream.
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_comb begin
        count_d = 2'd0;
        case (state_d)
            S_ONE:   count_d = 2'd1;
            S_TWO:   count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            skid_q      <= '0;
            count_r     <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_r <= (state_d != S_EMPTY);
            out_data_r  <= head_d;
            skid_q      <= skid_d;
            count_r     <= count_d;
        end
    end

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(fifo_pop && fifo_empty_r));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_r <= 2'd2);

    a_stable_backpressure: assert property (@(posedge clk) disable iff (rst)
        (out_valid_r && !out_ready && !flush) |=> (out_valid_r && $stable(out_data_r)));

endmodule
